// File: rtl/gf_inv_seq_if.sv
// Handshake bundle for gf_inv_seq: operand in, inverse out, plus busy status.
interface gf_inv_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/gf_inv_seq.sv
// Iterative GF(2^WIDTH) inverter computing a^(2^WIDTH-2) with one squarer and one multiplier.
// Optional macro GF_INV_SELFCHECK_EN adds chk_err, which flags operand*result != 1.
module gf_inv_seq #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1B)
) (
   input logic         clk,
   input logic         rst,
   gf_inv_seq_if.slave bus
`ifdef GF_INV_SELFCHECK_EN
   ,
   output logic        chk_err
`endif
);

   localparam int              CW   = $clog2(WIDTH);
   localparam int              PW   = 2 * WIDTH - 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 2);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sq;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             valid;
   logic             busy_r;
   logic [WIDTH-1:0] sq_nxt;
   logic [WIDTH-1:0] acc_nxt;

   // Fold every bit at or above x^WIDTH back using x^WIDTH = POLY.
   function automatic logic [WIDTH-1:0] gf_reduce(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      logic [PW-1:0] m;
      r = p;
      m = PW'({1'b1, POLY});
      for (int k = PW - 1; k >= WIDTH; k--) begin
         if (r[k]) r = r ^ (m << (k - WIDTH));
      end
      return r[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (y[i]) p = p ^ (PW'(x) << i);
      end
      return gf_reduce(p);
   endfunction

   // Squaring in characteristic 2 just spreads the bits to even positions.
   function automatic logic [WIDTH-1:0] gf_sq(input logic [WIDTH-1:0] x);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < WIDTH; i++) begin
         p[2*i] = x[i];
      end
      return gf_reduce(p);
   endfunction

   assign sq_nxt  = gf_sq(sq);
   assign acc_nxt = gf_mul(acc, sq_nxt);

`ifdef GF_INV_SELFCHECK_EN
   logic [WIDTH-1:0] operand;
   logic             chk_nxt;
   assign chk_nxt = (operand != '0) && (gf_mul(operand, acc_nxt) != ONE);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sq     <= '0;
         acc    <= '0;
         cnt    <= '0;
         valid  <= 1'b0;
         busy_r <= 1'b0;
`ifdef GF_INV_SELFCHECK_EN
         operand <= '0;
         chk_err <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sq     <= bus.in_data;
                  acc    <= ONE;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= CALC;
`ifdef GF_INV_SELFCHECK_EN
                  operand <= bus.in_data;
`endif
               end
            end
            // acc collects a^(2^1) * a^(2^2) * ... * a^(2^(WIDTH-1)).
            CALC: begin
               sq  <= sq_nxt;
               acc <= acc_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  valid <= 1'b1;
                  state <= DONE;
`ifdef GF_INV_SELFCHECK_EN
                  chk_err <= chk_nxt;
`endif
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid  <= 1'b0;
                  busy_r <= 1'b0;
                  state  <= IDLE;
`ifdef GF_INV_SELFCHECK_EN
                  chk_err <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = valid;
   assign bus.out_data  = acc;
   assign bus.busy      = busy_r;

endmodule
